dma_io_responder: RTL

I/O-side responder for the DMA bus protocol. It is instantiated once per I/O port. With the default window at 192–223 it acts as I/O1; with the window at 224–255 it acts as I/O2. Toward the DMA, it accepts words the DMA writes into its address window and raises an I/O-pending request when it has data of its own to deliver, then hands that data over on acknowledge. Toward the device, it buffers traffic in both directions in two FIFOs.

---
 rtl/dma_io_responder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_io_responder.sv
// dma_io_responder: DMA-bus I/O port responder.
// Decodes DMA writes into a TX FIFO toward the device, and delivers device words
// from an RX FIFO to the DMA through a REQ/XFER handshake.
module dma_io_responder #(
    parameter int unsigned BASE_ADDR = 192,
    parameter int unsigned WINDOW    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned RX_DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        D_address,
    input  logic              D_IOWrite,
    input  logic              D_IOAck,
    input  logic [DATA_W-1:0] data_in,
    output logic              IOIP,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              dev_pop,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              tx_empty,
    input  logic              dev_push,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic              rx_full,
    output logic              tx_overflow,
    output logic              rx_overflow,
    output logic              ack_err
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [8:0] WIN_LO = 9'(BASE_ADDR);
    localparam logic [8:0] WIN_HI = 9'(BASE_ADDR + WINDOW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO (DMA -> device)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr;
    logic [TX_AW-1:0]  tx_rd_ptr;
    logic [TX_CW-1:0]  tx_count;
    logic [TX_CW-1:0]  tx_count_nxt;
    logic [8:0]        addr9;
    logic              tx_hit;
    logic              tx_is_full;
    logic              tx_pop;
    logic              tx_push;
    logic              tx_drop;
    logic [DATA_W-1:0] tx_head_nxt;

    // Window decode, push/pop qualification and next head value for the registered dev_rdata.
    always_comb begin
        addr9        = {1'b0, D_address};
        tx_hit       = D_IOWrite && (addr9 >= WIN_LO) && (addr9 < WIN_HI);
        tx_is_full   = (tx_count == TX_CW'(TX_DEPTH));
        tx_pop       = dev_pop && (tx_count != '0);
        tx_push      = tx_hit && (!tx_is_full || tx_pop);
        tx_drop      = tx_hit && tx_is_full && !dev_pop;
        tx_count_nxt = tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
        tx_head_nxt  = dev_rdata;
        if (tx_pop) begin
            // A lone remaining word is replaced by the same-cycle write, if any.
            tx_head_nxt = (tx_count == TX_CW'(1)) ? data_in : tx_mem[tx_rd_ptr + TX_AW'(1)];
        end else if (tx_push && (tx_count == '0)) begin
            tx_head_nxt = data_in;
        end
    end

    // TX storage write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= data_in;
        end
    end

    // TX pointers, occupancy, registered head/empty and overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_count    <= '0;
            dev_rdata   <= '0;
            tx_empty    <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            end
            tx_count  <= tx_count_nxt;
            dev_rdata <= tx_head_nxt;
            tx_empty  <= (tx_count_nxt == '0);
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (device -> DMA) and handshake FSM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr;
    logic [RX_AW-1:0]  rx_rd_ptr;
    logic [RX_CW-1:0]  rx_count;
    logic [RX_CW-1:0]  rx_count_nxt;
    logic              rx_is_full;
    logic              rx_pop;
    logic              rx_push;
    logic              rx_drop;

    state_t            state_q;
    state_t            state_nxt;
    logic              ack_err_set;

    // RX push/pop qualification; the XFER pop frees a slot for a same-cycle push.
    always_comb begin
        rx_is_full   = (rx_count == RX_CW'(RX_DEPTH));
        rx_pop       = (state_q == XFER);
        rx_push      = dev_push && (!rx_is_full || rx_pop);
        rx_drop      = dev_push && rx_is_full && !rx_pop;
        rx_count_nxt = rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end

    // Handshake next-state logic; an ack outside REQ is flagged and otherwise ignored.
    always_comb begin
        state_nxt   = state_q;
        ack_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (D_IOAck) begin
                    ack_err_set = 1'b1;
                end
                if (rx_count != '0) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (D_IOAck) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (D_IOAck) begin
                    ack_err_set = 1'b1;
                end
                state_nxt = (rx_count_nxt != '0) ? REQ : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RX storage write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= dev_wdata;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // RX pointers, occupancy, full/overflow flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            rx_full     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            end
            rx_count <= rx_count_nxt;
            rx_full  <= (rx_count_nxt == RX_CW'(RX_DEPTH));
            if (rx_drop) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    // DMA-facing outputs registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IOIP       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            ack_err    <= 1'b0;
        end else begin
            IOIP       <= (state_nxt == REQ);
            data_valid <= (state_nxt == XFER);
            if (state_nxt == XFER) begin
                data_out <= rx_mem[rx_rd_ptr];
            end
            if (ack_err_set) begin
                ack_err <= 1'b1;
            end
        end
    end

endmodule
